// File: rtl/ram_writefirst_if.sv
// ram_writefirst_if: port bundle for the write-first scratch RAM.
// The master drives enable, write enable, address and write data.
// The slave returns the registered read data.
interface ram_writefirst_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3
);
    logic                  ram_ena;
    logic                  wena;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data_in;
    logic [DATA_WIDTH-1:0] data_out;

    modport master (
        output ram_ena,
        output wena,
        output addr,
        output data_in,
        input  data_out
    );

    modport slave (
        input  ram_ena,
        input  wena,
        input  addr,
        input  data_in,
        output data_out
    );
endinterface : ram_writefirst_if

// File: rtl/ram_writefirst.sv
// ram_writefirst: single-port synchronous RAM in write-first mode.
// One address serves both read and write. A write stores data_in and shows
// it on data_out at the same edge; a read returns mem[addr] one clock later.
// The storage is a register file, so a synchronous reset clears every word
// in a single cycle.
// Optional build macro RAM_OUT_REG_EN adds a second output register that
// advances only when the port was enabled in the previous cycle. This gives
// 2-clock latency.
module ram_writefirst #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3,
    parameter int DEPTH      = 2 ** ADDR_WIDTH  // must equal 2**ADDR_WIDTH
) (
    input  logic              clk,
    input  logic              rst,
    ram_writefirst_if.slave   bus
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rd_q;     // read / write-first result register

    // Storage array: clear on reset, otherwise update the addressed word on an enabled write.
    // NOTE: This memory is cleared on reset because the block is a register file. A reset
    // loop like this cannot map onto a block RAM macro.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (bus.ram_ena && bus.wena) begin
            // NOTE: Non-blocking assignment keeps the read below seeing the pre-edge contents.
            // The write-first bypass is then explicit and not an ordering accident.
            mem[bus.addr] <= bus.data_in;
        end
    end

    // First output stage: a write forwards data_in, a read fetches the stored word, and a
    // disabled port holds the previous value.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q <= '0;
        end else if (bus.ram_ena) begin
            rd_q <= bus.wena ? bus.data_in : mem[bus.addr];
        end
    end

`ifdef RAM_OUT_REG_EN
    logic                  ena_q;    // ram_ena delayed to line up with rd_q
    logic [DATA_WIDTH-1:0] out_q;

    // Second output stage: advance only behind an enabled first-stage update.
    always_ff @(posedge clk) begin
        if (rst) begin
            ena_q <= 1'b0;
            out_q <= '0;
        end else begin
            ena_q <= bus.ram_ena;
            if (ena_q) begin
                out_q <= rd_q;
            end
        end
    end

    assign bus.data_out = out_q;
`else
    assign bus.data_out = rd_q;
`endif

endmodule : ram_writefirst

// File: tb/tb_ram_writefirst.sv
// tb_ram_writefirst: directed and random checks of ram_writefirst.
// The expected outputs come from a behavioural model of the memory contents.
// Inputs are driven on the falling edge. Outputs are sampled 1 ns after the rising edge.
module tb_ram_writefirst;

    localparam int DW    = 8;
    localparam int AW    = 3;
    localparam int DEPTH = 2 ** AW;

    logic clk = 1'b0;
    logic rst = 1'b0;

    ram_writefirst_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    ram_writefirst #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Reference model state.
    logic [DW-1:0] model_mem [DEPTH];
    logic [DW-1:0] model_rd;      // value the RAM presents after the edge
    logic [DW-1:0] model_out;     // value visible on data_out
`ifdef RAM_OUT_REG_EN
    logic          model_ena_prev;
`endif

    int tests  = 0;
    int failed = 0;

    task automatic check(input string tag, input logic [DW-1:0] observed,
                         input logic [DW-1:0] expected);
        tests++;
        assert (observed === expected)
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Apply one cycle of stimulus, advance the model by one edge, and check data_out.
    task automatic step(input string tag, input logic r, input logic ena,
                        input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        rst         = r;
        bus.ram_ena = ena;
        bus.wena    = we;
        bus.addr    = a;
        bus.data_in = d;
        @(posedge clk);
        if (r) begin
            foreach (model_mem[i]) model_mem[i] = '0;
            model_rd  = '0;
            model_out = '0;
`ifdef RAM_OUT_REG_EN
            model_ena_prev = 1'b0;
`endif
        end else begin
`ifdef RAM_OUT_REG_EN
            // The second stage shows last cycle's result if that cycle was enabled.
            if (model_ena_prev) model_out = model_rd;
            model_ena_prev = ena;
`endif
            if (ena) begin
                if (we) begin
                    model_mem[a] = d;
                    model_rd     = d;
                end else begin
                    model_rd = model_mem[a];
                end
            end
`ifndef RAM_OUT_REG_EN
            model_out = model_rd;
`endif
        end
        #1;
        check(tag, bus.data_out, model_out);
    endtask

    initial begin
        bus.ram_ena = 1'b0;
        bus.wena    = 1'b0;
        bus.addr    = '0;
        bus.data_in = '0;

        // Reset, then read back every word.
        step("reset", 1'b1, 1'b1, 1'b0, 3'd0, 8'h00);
        check("reset_const", bus.data_out, 8'h00);
        for (int i = 0; i < DEPTH; i++) begin
            step("reset_read", 1'b0, 1'b1, 1'b0, AW'(i), 8'h00);
        end

        // Write-first behaviour.
        step("wf_write", 1'b0, 1'b1, 1'b1, 3'd0, 8'd3);
`ifdef RAM_OUT_REG_EN
        check("wf_first_edge_const", bus.data_out, 8'h00);
        step("wf_second_edge", 1'b0, 1'b1, 1'b0, 3'd0, 8'h00);
        check("wf_second_edge_const", bus.data_out, 8'd3);
`else
        check("wf_write_const", bus.data_out, 8'd3);
        step("wf_hold_read", 1'b0, 1'b1, 1'b0, 3'd0, 8'h00);
        check("wf_hold_const", bus.data_out, 8'd3);
`endif

        // Independent addresses.
        step("wr_a5", 1'b0, 1'b1, 1'b1, 3'd2, 8'hA5);
        step("wr_5a", 1'b0, 1'b1, 1'b1, 3'd5, 8'h5A);
        step("rd_2",  1'b0, 1'b1, 1'b0, 3'd2, 8'h00);
        step("rd_5",  1'b0, 1'b1, 1'b0, 3'd5, 8'h00);
        step("rd_0",  1'b0, 1'b1, 1'b0, 3'd0, 8'h00);

        // Enable gating: a disabled write must neither store nor change data_out.
        step("gate_hold", 1'b0, 1'b0, 1'b1, 3'd2, 8'hFF);
        step("gate_hold2", 1'b0, 1'b0, 1'b0, 3'd3, 8'hFF);
        step("gate_rd_2", 1'b0, 1'b1, 1'b0, 3'd2, 8'h00);
        step("gate_rd_2b", 1'b0, 1'b1, 1'b0, 3'd2, 8'h00);
        check("gate_rd_2_const", bus.data_out, 8'hA5);

        // Overwrite, then reset in the middle of operation.
        step("ow_11", 1'b0, 1'b1, 1'b1, 3'd7, 8'h11);
        step("ow_22", 1'b0, 1'b1, 1'b1, 3'd7, 8'h22);
        step("ow_rst", 1'b1, 1'b1, 1'b1, 3'd7, 8'h77);
        step("ow_rd_7", 1'b0, 1'b1, 1'b0, 3'd7, 8'h00);
        step("ow_rd_7b", 1'b0, 1'b1, 1'b0, 3'd7, 8'h00);
        check("ow_rd_7_const", bus.data_out, 8'h00);

        // Random traffic, with occasional resets.
        for (int n = 0; n < 400; n++) begin
            step("random",
                 ($urandom_range(0, 49) == 0),
                 ($urandom_range(0, 3) != 0),
                 $urandom_range(0, 1) == 1,
                 AW'($urandom_range(0, DEPTH - 1)),
                 DW'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule : tb_ram_writefirst
